// File: rtl/hazard_pkg.sv
// Shared types and defaults for the MIPS pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1
    } state_t;

    localparam int MD_LATENCY_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    // Register $0 is hardwired to zero, so it never carries a true dependence.
    function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, mult/div EX freeze, branch squash, perf counters.
// Optional macro FORWARDING_EN: when defined, only load-use hazards stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic             idex_regwrite,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic             branch_taken,
    input  logic             md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MD_CNT_W = (MD_LATENCY > 3) ? $clog2(MD_LATENCY - 1) : 1;
    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LATENCY - 2);

    state_t              state;
    logic [MD_CNT_W-1:0] md_cnt;

    logic dep_idex;
    logic dep_exmem;
    logic load_use;
    logic data_hazard;
    logic md_trigger;
    logic md_hold;
    logic freeze;
    logic stall_inc;
    logic flush_inc;

    assign dep_idex  = src_match(id_rs, idex_rd)  | (id_uses_rt & src_match(id_rt, idex_rd));
    assign dep_exmem = src_match(id_rs, exmem_rd) | (id_uses_rt & src_match(id_rt, exmem_rd));
    assign load_use  = idex_memread & dep_idex;

`ifdef FORWARDING_EN
    // Forwarding covers ALU results in EX/MEM and MEM/WB; only loads stall.
    logic unused_fwd;
    assign unused_fwd  = ^{idex_regwrite, exmem_regwrite, dep_exmem};
    assign data_hazard = load_use;
`else
    assign data_hazard = load_use
                       | (idex_regwrite  & dep_idex)
                       | (exmem_regwrite & dep_exmem);
`endif

    // md_start is only honoured from RUN; the release cycle ignores it.
    assign md_trigger = (state == RUN) && md_start;
    assign md_hold    = (state == MD_BUSY) && (md_cnt != '0);
    assign freeze     = md_trigger || md_hold;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        md_busy      = (state == MD_BUSY);
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            md_busy      = 1'b0;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else if (data_hazard) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else if (branch_taken) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_CNT_INIT;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != '0) begin
                        md_cnt <= md_cnt - MD_CNT_W'(1);
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    assign stall_inc = !rst && !pc_write;
    assign flush_inc = !rst && branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (default and CNT_W=4 instances).
module tb_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Output vector order: {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, md_busy}
    localparam logic [6:0] O_RUN    = 7'b111_000_0;
    localparam logic [6:0] O_STALL  = 7'b001_010_0;
    localparam logic [6:0] O_FRZ0   = 7'b000_001_0;
    localparam logic [6:0] O_FRZ1   = 7'b000_001_1;
    localparam logic [6:0] O_REL    = 7'b111_000_1;
    localparam logic [6:0] O_RELHZ  = 7'b001_010_1;
    localparam logic [6:0] O_BR0    = 7'b111_111_0;
    localparam logic [6:0] O_BR1    = 7'b111_111_1;
    localparam logic [6:0] O_RST    = 7'b000_111_0;

    logic clk;
    logic rst;
    logic [4:0] id_rs, id_rt, idex_rd, exmem_rd;
    logic id_uses_rt, idex_memread, idex_regwrite, exmem_regwrite, branch_taken, md_start;

    logic pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, md_busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_write, s_ifid_write, s_idex_write, s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_md_busy;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_rd(idex_rd),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .branch_taken(branch_taken),
        .md_start(md_start), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .md_busy(md_busy), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_rd(idex_rd),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .branch_taken(branch_taken),
        .md_start(md_start), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_write(s_idex_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .exmem_bubble(s_exmem_bubble), .md_busy(s_md_busy), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic       regwrite;
        logic [4:0] xrd;
        logic       mregwrite;
        logic [4:0] mrd;
        logic       br;
        logic [6:0] exp_nf;
        logic [6:0] exp_f;
    } vec_t;

    vec_t vecs[11];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic memread, input logic regwrite, input logic [4:0] xrd,
                                input logic mregwrite, input logic [4:0] mrd, input logic br,
                                input logic [6:0] exp_nf, input logic [6:0] exp_f);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.memread = memread; v.regwrite = regwrite;
        v.xrd = xrd; v.mregwrite = mregwrite; v.mrd = mrd; v.br = br;
        v.exp_nf = exp_nf; v.exp_f = exp_f;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [6:0] exp);
        check(nm, {25'd0, pc_write, ifid_write, idex_write, ifid_flush, idex_bubble,
                   exmem_bubble, md_busy}, {25'd0, exp});
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; idex_memread = 1'b0;
        idex_regwrite = 1'b0; idex_rd = 5'd0; exmem_regwrite = 1'b0; exmem_rd = 5'd0;
        branch_taken = 1'b0; md_start = 1'b0;
    endtask

    task automatic load_use_on();
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd8; id_rs = 5'd8;
    endtask

    task automatic load_use_off();
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = 5'd0; id_rs = 5'd0;
    endtask

    initial begin
        logic [6:0] e;
        vecs[0]  = mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, O_RUN,   O_RUN);
        vecs[1]  = mk(5'd8,  5'd0, 1'b0, 1'b1, 1'b0, 5'd8,  1'b0, 5'd0, 1'b0, O_STALL, O_STALL);
        vecs[2]  = mk(5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, O_RUN,   O_RUN);
        vecs[3]  = mk(5'd2,  5'd9, 1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 5'd0, 1'b0, O_STALL, O_STALL);
        vecs[4]  = mk(5'd3,  5'd9, 1'b0, 1'b1, 1'b0, 5'd9,  1'b0, 5'd0, 1'b0, O_RUN,   O_RUN);
        vecs[5]  = mk(5'd1,  5'd5, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd5, 1'b0, O_STALL, O_RUN);
        vecs[6]  = mk(5'd7,  5'd0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 5'd0, 1'b0, O_STALL, O_RUN);
        vecs[7]  = mk(5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0, 1'b0, O_RUN,   O_RUN);
        vecs[8]  = mk(5'd8,  5'd0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0, 1'b1, O_BR0,   O_BR0);
        vecs[9]  = mk(5'd5,  5'd6, 1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 5'd3, 1'b0, O_RUN,   O_RUN);
        vecs[10] = mk(5'd12, 5'd0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, O_STALL, O_STALL);

        // Reset
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_out("reset_outputs", O_RST);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vectors from RUN
        for (int i = 0; i < 11; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            idex_memread = vecs[i].memread; idex_regwrite = vecs[i].regwrite;
            idex_rd = vecs[i].xrd; exmem_regwrite = vecs[i].mregwrite;
            exmem_rd = vecs[i].mrd; branch_taken = vecs[i].br; md_start = 1'b0;
            e = FWD ? vecs[i].exp_f : vecs[i].exp_nf;
            #1;
            chk_out($sformatf("vec%0d", i), e);
            check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_stall));
            if (!e[6]) exp_stall++;
            if (vecs[i].br) exp_flush++;
            @(negedge clk);
        end
        idle();
        #1;
        check("table_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

        // MD sequence: 3 frozen cycles, md_busy for 3 cycles, then RUN
        @(negedge clk);
        md_start = 1'b1;
        #1; chk_out("md_k0", O_FRZ0); exp_stall++;
        @(negedge clk); #1; chk_out("md_k1", O_FRZ1); exp_stall++;
        @(negedge clk); #1; chk_out("md_k2", O_FRZ1); exp_stall++;
        @(negedge clk); #1; chk_out("md_release", O_REL);
        @(negedge clk); md_start = 1'b0;
        #1; chk_out("md_done", O_RUN);
        check("md_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Branch aborts an MD sequence on the 2nd frozen cycle
        @(negedge clk);
        md_start = 1'b1;
        #1; chk_out("abort_k0", O_FRZ0); exp_stall++;
        @(negedge clk); branch_taken = 1'b1;
        #1; chk_out("abort_branch", O_BR1); exp_flush++;
        @(negedge clk); branch_taken = 1'b0; md_start = 1'b0;
        #1; chk_out("abort_after", O_RUN);
        check("abort_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

        // Branch together with md_start in RUN: branch wins, state stays RUN
        @(negedge clk);
        branch_taken = 1'b1; md_start = 1'b1;
        #1; chk_out("br_md_same", O_BR0); exp_flush++;
        @(negedge clk); idle();
        #1; chk_out("br_md_after", O_RUN);

        // Hazard during freeze is masked; hazard in release cycle stalls
        @(negedge clk);
        md_start = 1'b1;
        #1; chk_out("mdhz_k0", O_FRZ0); exp_stall++;
        @(negedge clk); load_use_on();
        #1; chk_out("mdhz_k1", O_FRZ1); exp_stall++;
        @(negedge clk); load_use_off();
        #1; chk_out("mdhz_k2", O_FRZ1); exp_stall++;
        @(negedge clk); load_use_on();
        #1; chk_out("mdhz_release", O_RELHZ); exp_stall++;
        @(negedge clk); idle();
        #1; chk_out("mdhz_done", O_RUN);
        check("mdhz_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check("mdhz_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

        // 20 load-use stall cycles: 4-bit counter saturates
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); load_use_on();
            #1;
            if (k == 0 || k == 19) chk_out($sformatf("sat_stall%0d", k), O_STALL);
            exp_stall++;
        end
        @(negedge clk); idle();
        #1;
        check("sat_main_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check("sat_small_stall_cnt", 32'(s_stall_cnt), 32'((exp_stall > 15) ? 15 : exp_stall));
        check("sat_small_flush_cnt", 32'(s_flush_cnt), 32'(exp_flush));

        // Reset mid-MD
        @(negedge clk);
        md_start = 1'b1;
        #1; chk_out("rstmd_k0", O_FRZ0);
        @(negedge clk); rst = 1'b1;
        #1; chk_out("rstmd_in_rst", O_RST);
        @(negedge clk); rst = 1'b0; md_start = 1'b0;
        #1; chk_out("rstmd_after", O_RUN);
        check("rstmd_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rstmd_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rstmd_small_stall_cnt", 32'(s_stall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
